// File: rtl/control_proto_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | control_proto_pkg                                                    |
// | Shared constants and state encodings for the nibble-over-UART host.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package control_proto_pkg;

  localparam logic [3:0] NIBBLE_TAG    = 4'h4;
  localparam logic [7:0] CMD_SHIFT_OUT = 8'h6F;
  localparam logic [7:0] RESP_HDR      = 8'h07;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_SEND  = 4'd1,
    WR_GAP   = 4'd2,
    WR_WAIT  = 4'd3,
    CMD_SEND = 4'd4,
    CMD_GAP  = 4'd5,
    CMD_WAIT = 4'd6,
    RX_HDR   = 4'd7,
    RX_DATA  = 4'd8
  } host_state_e;

  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_SEND = 2'd1,
    HS_GAP  = 2'd2,
    HS_WAIT = 2'd3
  } hs_state_e;

  // Room for the largest nibble count plus the surplus reply nibble.
  function automatic int cnt_width(input int nib_a, input int nib_b);
    int m;
    m = (nib_a > nib_b) ? nib_a : nib_b;
    return $clog2(m + 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_host_txhs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | control_host_txhs                                                    |
// | One-byte SEND/GAP/WAIT handshake towards a uart_tx byte module.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module control_host_txhs
  import control_proto_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [7:0] req_byte,
  output logic       ack,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy
);

  hs_state_e  hs_q, hs_d;
  logic [7:0] tx_data_q, tx_data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q      <= HS_IDLE;
      tx_data_q <= '0;
    end else begin
      hs_q      <= hs_d;
      tx_data_q <= tx_data_d;
    end
  end

  always_comb begin
    hs_d      = hs_q;
    tx_data_d = tx_data_q;
    case (hs_q)
      HS_IDLE: begin
        if (req) begin
          hs_d      = HS_SEND;
          tx_data_d = req_byte;
        end
      end
      HS_SEND: hs_d = HS_GAP;
      // GAP gives uart_tx one cycle to raise tx_busy before it is polled.
      HS_GAP:  hs_d = HS_WAIT;
      HS_WAIT: if (!tx_busy) hs_d = HS_IDLE;
      default: hs_d = HS_IDLE;
    endcase
  end

  always_comb begin
    tx_start = (hs_q == HS_SEND);
    ack      = (hs_q == HS_WAIT) && !tx_busy;
    tx_data  = tx_data_q;
  end

endmodule
`default_nettype wire

// File: rtl/control_host.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | control_host                                                         |
// | Host side of the nibble-over-UART control protocol: writes a word as |
// | 0x4N bytes, issues 0x6F, collects the 0x07-headed nibble reply.      |
// | Optional reply timeout: define CONTROL_HOST_TIMEOUT_EN.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module control_host
  import control_proto_pkg::*;
#(
  parameter int DOUT_WIDTH     = 64,
  parameter int DIN_WIDTH      = 64,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DOUT_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DIN_WIDTH-1:0]  rd_data,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_busy,
  input  logic                  rx_ready,
  input  logic [7:0]            rx_data
);

  localparam int DOUT_NIBBLES = (DOUT_WIDTH + 3) / 4;
  localparam int DIN_NIBBLES  = (DIN_WIDTH + 3) / 4;
  localparam int CNT_W        = cnt_width(DOUT_NIBBLES, DIN_NIBBLES);
  localparam logic [CNT_W-1:0] NIB_TOP  = CNT_W'(DOUT_NIBBLES - 1);
  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(DIN_NIBBLES);

  host_state_e            state_q, state_d;
  logic [CNT_W-1:0]       nib_q, nib_d, idx_q, idx_d;
  logic [DOUT_WIDTH-1:0]  wr_q, wr_d;
  logic [DIN_WIDTH-1:0]   shadow_q, shadow_d, rd_q, rd_d;
  logic                   done_q, done_d, error_q, error_d;

  logic       w_hs_req, w_hs_ack;
  logic [7:0] w_hs_byte;
  logic [3:0] w_cur_nibble;
  logic       w_accept, w_rx_hdr, w_rx_dat, w_hdr_ok, w_tag_ok, w_last;
  logic       w_finish, w_abort, w_timeout;

  // A start landing in the done/error cycle is ignored, even though busy is already low.
  assign w_accept = (state_q == IDLE) && start && !done_q && !error_q;
  assign w_rx_hdr = (state_q == RX_HDR) && rx_ready;
  assign w_rx_dat = (state_q == RX_DATA) && rx_ready;
  assign w_hdr_ok = (rx_data == RESP_HDR);
  assign w_tag_ok = (rx_data[7:4] == NIBBLE_TAG);
  assign w_last   = (idx_q == IDX_LAST);
  assign w_finish = w_rx_dat && w_tag_ok && w_last;
  assign w_abort  = (w_rx_hdr && !w_hdr_ok) || (w_rx_dat && !w_tag_ok) || w_timeout;

`ifdef CONTROL_HOST_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             w_in_rx;

  assign w_in_rx   = (state_q == RX_HDR) || (state_q == RX_DATA);
  assign w_timeout = w_in_rx && !rx_ready && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = '0;
    if (w_in_rx && !rx_ready) tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`else
  // No reply timer: never fires.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (w_accept) state_d = WR_SEND;
      WR_SEND:  state_d = WR_GAP;
      WR_GAP:   state_d = WR_WAIT;
      WR_WAIT:  if (w_hs_ack) state_d = (nib_q == '0) ? CMD_SEND : WR_SEND;
      CMD_SEND: state_d = CMD_GAP;
      CMD_GAP:  state_d = CMD_WAIT;
      CMD_WAIT: if (w_hs_ack) state_d = RX_HDR;
      RX_HDR:   if (w_rx_hdr && w_hdr_ok) state_d = RX_DATA;
      RX_DATA:  state_d = RX_DATA;
      default:  state_d = IDLE;
    endcase
    if (w_finish || w_abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nib_q    <= '0;
      idx_q    <= '0;
      wr_q     <= '0;
      shadow_q <= '0;
      rd_q     <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      nib_q    <= nib_d;
      idx_q    <= idx_d;
      wr_q     <= wr_d;
      shadow_q <= shadow_d;
      rd_q     <= rd_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    nib_d    = nib_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    shadow_d = shadow_q;
    rd_d     = rd_q;
    done_d   = w_finish;
    error_d  = w_abort;
    if (w_accept) begin
      wr_d  = wr_data;
      nib_d = NIB_TOP;
    end
    if ((state_q == WR_WAIT) && w_hs_ack && (nib_q != '0)) nib_d = nib_q - 1'b1;
    if (w_rx_hdr && w_hdr_ok) idx_d = '0;
    if (w_rx_dat && w_tag_ok) begin
      // The surplus final nibble matches no shadow slot and is dropped.
      for (int b = 0; b < DIN_WIDTH; b++) begin
        if (idx_q == CNT_W'(b / 4)) shadow_d[b] = rx_data[b % 4];
      end
      if (!w_last) idx_d = idx_q + 1'b1;
    end
    if (w_finish) rd_d = shadow_q;
  end

  // Nibbles beyond DOUT_WIDTH read as zero.
  always_comb begin
    w_cur_nibble = '0;
    for (int b = 0; b < DOUT_WIDTH; b++) begin
      if (nib_q == CNT_W'(b / 4)) w_cur_nibble[b % 4] = wr_q[b];
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done      = done_q;
    error     = error_q;
    rd_data   = rd_q;
    w_hs_req  = (state_q == WR_SEND) || (state_q == CMD_SEND);
    w_hs_byte = (state_q == CMD_SEND) ? CMD_SHIFT_OUT : {NIBBLE_TAG, w_cur_nibble};
  end

  control_host_txhs u_txhs (
    .clk      (clk),
    .rst_n    (reset_n),
    .req      (w_hs_req),
    .req_byte (w_hs_byte),
    .ack      (w_hs_ack),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy)
  );

endmodule
`default_nettype wire
